// File: rtl/rca_pipelined_if.sv
// -----------------------------------------------------------------------------
// rca_pipelined_if
//   Bundles the operand/result signals of rca_pipelined so a producer and a
//   consumer can share one handle. The adder keeps its own flat ports; the
//   instantiating module wires the interface members to them.
//
//   Signals:
//     a, b      WIDTH  operands, presented every clock
//     cin       1      carry-in travelling with a/b
//     sum       WIDTH  result sum, WIDTH register edges after the operands
//     cout      1      result carry-out
//     in_valid  1      (RCA_VALID_EN only) marks a meaningful operand pair
//     out_valid 1      (RCA_VALID_EN only) marks a meaningful result
//
//   Handshake: there is no back-pressure. The master presents a pair on every
//   rising edge and the slave always accepts it; results appear a fixed
//   latency later. With RCA_VALID_EN, valid only qualifies data, it never
//   stalls anything.
//
//   Optional macro: RCA_VALID_EN adds the in_valid/out_valid members.
// -----------------------------------------------------------------------------
interface rca_pipelined_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef RCA_VALID_EN
    logic             in_valid;
    logic             out_valid;
`endif

`ifdef RCA_VALID_EN
    modport master (output a, output b, output cin, output in_valid,
                    input  sum, input cout, input out_valid);
    modport slave  (input  a, input  b, input  cin, input  in_valid,
                    output sum, output cout, output out_valid);
`else
    modport master (output a, output b, output cin,
                    input  sum, input cout);
    modport slave  (input  a, input  b, input  cin,
                    output sum, output cout);
`endif
endinterface

// File: rtl/rca_pipelined.sv
// -----------------------------------------------------------------------------
// rca_pipelined
//   WIDTH-bit ripple-carry adder with one full-adder and one register stage
//   per bit. A new operand pair is accepted on every rising edge and
//   {cout,sum} = a + b + cin appears WIDTH register edges later (the
//   sampling edge counts as the first). No stalls, no overflow flag.
//
//   Ports:
//     a, b      in   WIDTH  operands, sampled every rising edge
//     cin       in   1      carry-in, sampled with a/b
//     clock     in   1      rising-edge clock
//     sum       out  WIDTH  registered sum
//     cout      out  1      registered carry-out
//     rst_n     in   1      synchronous active-low reset
//     in_valid  in   1      (RCA_VALID_EN only) qualifies the sampled pair
//     out_valid out  1      (RCA_VALID_EN only) qualifies sum/cout
//
//   Optional macro: RCA_VALID_EN adds a valid bit that shifts alongside the
//   data. The data path itself is identical with or without it.
//
//   Each stage k holds a working word r_v[k]: bits 0..k are finished sum bits
//   and bits above k are still the untouched A operand bits. B travels in its
//   own skew register r_b[k], and r_c[k] is the carry into bit k+1. Stage k
//   therefore only ever adds bit k of the word it receives, which keeps the
//   combinational depth to a single full adder.
// -----------------------------------------------------------------------------
module rca_pipelined #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clock,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic             rst_n
`ifdef RCA_VALID_EN
    ,
    input  logic             in_valid,
    output logic             out_valid
`endif
);

    // Stage registers
    logic [WIDTH-1:0] r_v [WIDTH];
    logic [WIDTH-1:0] r_b [WIDTH];
    logic             r_c [WIDTH];

    // Per-stage inputs and next-state values
    logic [WIDTH-1:0] w_v_in  [WIDTH];
    logic [WIDTH-1:0] w_b_in  [WIDTH];
    logic             w_c_in  [WIDTH];
    logic             w_fa_s  [WIDTH];
    logic             w_fa_c  [WIDTH];
    logic [WIDTH-1:0] w_v_nxt [WIDTH];

    for (genvar k = 0; k < WIDTH; k++) begin : g_stage
        localparam logic [WIDTH-1:0] BIT_K = WIDTH'(1) << k;

        // Stage 0 takes the raw inputs; later stages take the previous stage.
        if (k == 0) begin : g_first
            assign w_v_in[k] = a;
            assign w_b_in[k] = b;
            assign w_c_in[k] = cin;
        end else begin : g_rest
            assign w_v_in[k] = r_v[k-1];
            assign w_b_in[k] = r_b[k-1];
            assign w_c_in[k] = r_c[k-1];
        end

        assign w_fa_s[k] = w_v_in[k][k] ^ w_b_in[k][k] ^ w_c_in[k];
        assign w_fa_c[k] = (w_v_in[k][k] & w_b_in[k][k])
                         | (w_v_in[k][k] & w_c_in[k])
                         | (w_b_in[k][k] & w_c_in[k]);

        // Overwrite the consumed A bit with the finished sum bit.
        assign w_v_nxt[k] = (w_v_in[k] & ~BIT_K) | ({WIDTH{w_fa_s[k]}} & BIT_K);
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int k = 0; k < WIDTH; k++) begin
                r_v[k] <= '0;
                r_b[k] <= '0;
                r_c[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                r_v[k] <= w_v_nxt[k];
                r_b[k] <= w_b_in[k];
                r_c[k] <= w_fa_c[k];
            end
        end
    end

    // After the last stage every bit of the working word is a sum bit.
    assign sum  = r_v[WIDTH-1];
    assign cout = r_c[WIDTH-1];

`ifdef RCA_VALID_EN
    logic r_vld [WIDTH];

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int k = 0; k < WIDTH; k++) begin
                r_vld[k] <= 1'b0;
            end
        end else begin
            r_vld[0] <= in_valid;
            for (int k = 1; k < WIDTH; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    assign out_valid = r_vld[WIDTH-1];
`endif

endmodule

// File: tb/tb_rca_pipelined.sv
// -----------------------------------------------------------------------------
// tb_rca_pipelined
//   Directed bench for rca_pipelined with WIDTH=4. Every applied pair pushes
//   its hand-computed result into exp_q; once the queue holds WIDTH entries
//   (the pipeline depth) the oldest entry is due on the outputs after the
//   current edge. While the pipeline is still filling after a reset the
//   outputs must read 0. Compile with RCA_VALID_EN to also cover out_valid.
// -----------------------------------------------------------------------------
module tb_rca_pipelined;
    localparam int WIDTH = 4;
    localparam int EW    = WIDTH + 2;   // {valid, cout, sum}

    logic clock;
    logic rst_n;

    rca_pipelined_if #(.WIDTH(WIDTH)) bus ();

    rca_pipelined #(.WIDTH(WIDTH)) dut (
        .a         (bus.a),
        .b         (bus.b),
        .cin       (bus.cin),
        .clock     (clock),
        .sum       (bus.sum),
        .cout      (bus.cout),
        .rst_n     (rst_n)
`ifdef RCA_VALID_EN
        ,
        .in_valid  (bus.in_valid),
        .out_valid (bus.out_valid)
`endif
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            checks;
    int            errors;

    function automatic logic [EW-1:0] observed();
`ifdef RCA_VALID_EN
        return {bus.out_valid, bus.cout, bus.sum};
`else
        return {1'b0, bus.cout, bus.sum};
`endif
    endfunction

    task automatic check(input string tag, input logic [EW-1:0] exp);
        logic [EW-1:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed {v,cout,sum}=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                              input logic op_c, input logic op_v);
        bus.a   = op_a;
        bus.b   = op_b;
        bus.cin = op_c;
`ifdef RCA_VALID_EN
        bus.in_valid = op_v;
`else
        if (op_v) begin end
`endif
    endtask

    // One edge with a pair sampled under rst_n=1; exp_sum is {cout,sum}.
    task automatic drive_pair(input string tag,
                              input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                              input logic op_c, input logic op_v,
                              input logic [WIDTH:0] exp_sum);
        logic [EW-1:0] e;
        rst_n = 1'b1;
        set_inputs(op_a, op_b, op_c, op_v);
`ifdef RCA_VALID_EN
        exp_q.push_back({op_v, exp_sum});
`else
        exp_q.push_back({1'b0, exp_sum});
`endif
        @(posedge clock);
        #1;
        if (exp_q.size() >= WIDTH) begin
            e = exp_q.pop_front();
            check(tag, e);
        end else begin
            check({tag, "_fill"}, '0);
        end
    endtask

    // One edge with rst_n=0: all in-flight pairs and the presented pair die.
    task automatic reset_edge(input string tag,
                              input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
        rst_n = 1'b0;
        set_inputs(op_a, op_b, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        exp_q.delete();
        check(tag, '0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_inputs(4'd5, 4'd5, 1'b0, 1'b1);

        // Reset with a non-zero pair on the inputs for two edges.
        reset_edge("reset_0", 4'd5, 4'd5);
        reset_edge("reset_1", 4'd5, 4'd5);

        // After release: zero pairs, outputs stay 0 while the pipe fills.
        drive_pair("post_rst_0", 4'd0, 4'd0, 1'b0, 1'b1, 5'h00);
        drive_pair("post_rst_1", 4'd0, 4'd0, 1'b0, 1'b1, 5'h00);
        drive_pair("post_rst_2", 4'd0, 4'd0, 1'b0, 1'b1, 5'h00);

        // Basic add and carry ripple, back to back.
        drive_pair("basic_3p3",   4'd3,  4'd3,  1'b0, 1'b1, 5'h06);
        drive_pair("ripple_15p1", 4'd15, 4'd1,  1'b0, 1'b1, 5'h10);
        drive_pair("ripple_all",  4'd15, 4'd15, 1'b1, 1'b1, 5'h1F);
        drive_pair("cin_only",    4'd0,  4'd0,  1'b1, 1'b1, 5'h01);

        // Streaming a=b=0..4.
        drive_pair("stream_0", 4'd0, 4'd0, 1'b0, 1'b1, 5'h00);
        drive_pair("stream_1", 4'd1, 4'd1, 1'b0, 1'b1, 5'h02);
        drive_pair("stream_2", 4'd2, 4'd2, 1'b0, 1'b1, 5'h04);
        drive_pair("stream_3", 4'd3, 4'd3, 1'b0, 1'b1, 5'h06);
        drive_pair("stream_4", 4'd4, 4'd4, 1'b0, 1'b1, 5'h08);

        // Mixed patterns: msb carry, carry into bit 3, alternating bits.
        drive_pair("mix_8p8c",  4'd8,  4'd8,  1'b1, 1'b1, 5'h11);
        drive_pair("mix_7p8c",  4'd7,  4'd8,  1'b1, 1'b1, 5'h10);
        drive_pair("mix_10p5",  4'd10, 4'd5,  1'b0, 1'b1, 5'h0F);
        drive_pair("mix_12p6",  4'd12, 4'd6,  1'b1, 1'b1, 5'h13);

        // Valid pulses 1,0,1 with a=b=1,2,3.
        drive_pair("vld_1", 4'd1, 4'd1, 1'b0, 1'b1, 5'h02);
        drive_pair("vld_0", 4'd2, 4'd2, 1'b0, 1'b0, 5'h04);
        drive_pair("vld_1b", 4'd3, 4'd3, 1'b0, 1'b1, 5'h06);

        // Fill the pipe with distinctive pairs, then reset mid-stream.
        drive_pair("pre_rst_0", 4'd9, 4'd9, 1'b0, 1'b1, 5'h12);
        drive_pair("pre_rst_1", 4'd6, 4'd7, 1'b1, 1'b1, 5'h0E);
        drive_pair("pre_rst_2", 4'd15, 4'd14, 1'b0, 1'b1, 5'h1D);
        reset_edge("mid_reset", 4'd5, 4'd5);

        // Pre-reset pairs must never appear; new pairs come through cleanly.
        drive_pair("restart_0", 4'd1, 4'd2, 1'b0, 1'b1, 5'h03);
        drive_pair("restart_1", 4'd2, 4'd2, 1'b1, 1'b1, 5'h05);
        drive_pair("restart_2", 4'd15, 4'd0, 1'b1, 1'b1, 5'h10);
        drive_pair("restart_3", 4'd11, 4'd4, 1'b0, 1'b1, 5'h0F);

        // Flush the remaining expected results.
        drive_pair("flush_0", 4'd0, 4'd0, 1'b0, 1'b0, 5'h00);
        drive_pair("flush_1", 4'd0, 4'd0, 1'b0, 1'b0, 5'h00);
        drive_pair("flush_2", 4'd0, 4'd0, 1'b0, 1'b0, 5'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
